dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one memory port among load misses, fetch misses and
// store writebacks, and tracks outstanding reads in a tag table for zero-latency returns.
module dmem_port_arbiter #(
    parameter int B_W   = 4,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             ld_req,
    input  logic [31:0]      ld_addr,
    input  logic [B_W-1:0]   ld_bm,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    input  logic             st_req,
    input  logic [31:0]      st_addr,
    input  logic [63:0]      st_data,
    input  logic             st_urgent,

    output logic             ld_ack,
    output logic             if_ack,
    output logic             st_ack,

    input  logic [B_W-1:0]   b_mm_resolve,
    input  logic             b_mm_mispred,

    output logic [1:0]       proc2mem_command,
    output logic [31:0]      proc2mem_addr,
    output logic [63:0]      proc2mem_data,

    input  logic [TAG_W-1:0] mem2proc_transaction_tag,
    input  logic [TAG_W-1:0] mem2proc_data_tag,
    input  logic [63:0]      mem2proc_data,

    output logic             ld_resp_valid,
    output logic [63:0]      ld_resp_data,
    output logic [B_W-1:0]   ld_resp_bm,
    output logic             if_resp_valid,
    output logic [63:0]      if_resp_data,

    output logic [TAG_W-1:0] outstanding
);

    localparam int N = 1 << TAG_W;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [1:0] {
        SEL_LD   = 2'd0,
        SEL_IF   = 2'd1,
        SEL_ST   = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

    sel_e             winner;
    logic             ld_eligible;
    logic             accepted;
    logic             alloc;
    logic             ret_hit;
    logic [1:0]       ptr_q, ptr_d;

    logic [N-1:0]     valid_q, valid_d;
    logic [N-1:0]     owner_fetch_q, owner_fetch_d;
    logic [N-1:0]     squashed_q, squashed_d;
    logic [B_W-1:0]   bm_q [N];
    logic [B_W-1:0]   bm_d [N];
    logic [TAG_W-1:0] outstanding_q, outstanding_d;

    // A load being killed by this cycle's mispredict must not reach memory at all.
    always_comb begin
        ld_eligible = ld_req && !(b_mm_mispred && (|(ld_bm & b_mm_resolve)));
        winner      = SEL_NONE;
        if (st_req && st_urgent) begin
            winner = SEL_ST;
        end else begin
            case (ptr_q)
                2'd0: begin
                    if (ld_eligible)  winner = SEL_LD;
                    else if (if_req)  winner = SEL_IF;
                    else if (st_req)  winner = SEL_ST;
                end
                2'd1: begin
                    if (if_req)           winner = SEL_IF;
                    else if (st_req)      winner = SEL_ST;
                    else if (ld_eligible) winner = SEL_LD;
                end
                default: begin
                    if (st_req)           winner = SEL_ST;
                    else if (ld_eligible) winner = SEL_LD;
                    else if (if_req)      winner = SEL_IF;
                end
            endcase
        end
        if (reset) winner = SEL_NONE;

        accepted = (winner != SEL_NONE) && (mem2proc_transaction_tag != '0);
        alloc    = accepted && (winner != SEL_ST);
        ld_ack   = accepted && (winner == SEL_LD);
        if_ack   = accepted && (winner == SEL_IF);
        st_ack   = accepted && (winner == SEL_ST);

        proc2mem_command = CMD_NONE;
        proc2mem_addr    = 32'd0;
        proc2mem_data    = 64'd0;
        case (winner)
            SEL_LD: begin
                proc2mem_command = CMD_LOAD;
                proc2mem_addr    = ld_addr;
            end
            SEL_IF: begin
                proc2mem_command = CMD_LOAD;
                proc2mem_addr    = if_addr;
            end
            SEL_ST: begin
                proc2mem_command = CMD_STORE;
                proc2mem_addr    = st_addr;
                proc2mem_data    = st_data;
            end
            default: ;
        endcase

        ptr_d = ptr_q;
        if (accepted) begin
            case (winner)
                SEL_LD:  ptr_d = 2'd1;
                SEL_IF:  ptr_d = 2'd2;
                default: ptr_d = 2'd0;
            endcase
        end
    end

    // Responses are judged against the entry as it stands, including this cycle's resolve.
    always_comb begin
        ret_hit       = !reset && (mem2proc_data_tag != '0) && valid_q[mem2proc_data_tag];
        if_resp_valid = ret_hit && owner_fetch_q[mem2proc_data_tag];
        ld_resp_valid = ret_hit && !owner_fetch_q[mem2proc_data_tag]
                        && !squashed_q[mem2proc_data_tag]
                        && !(b_mm_mispred && (|(bm_q[mem2proc_data_tag] & b_mm_resolve)));
        ld_resp_bm    = bm_q[mem2proc_data_tag] & ~b_mm_resolve;
        ld_resp_data  = mem2proc_data;
        if_resp_data  = mem2proc_data;
    end

    // Table update order: branch resolution, then return clears, then allocation overrides.
    always_comb begin
        valid_d       = valid_q;
        owner_fetch_d = owner_fetch_q;
        squashed_d    = squashed_q;
        for (int i = 0; i < N; i++) begin
            bm_d[i] = bm_q[i];
            if (valid_q[i] && !owner_fetch_q[i] && (|(bm_q[i] & b_mm_resolve))) begin
                if (b_mm_mispred) squashed_d[i] = 1'b1;
                else              bm_d[i]       = bm_q[i] & ~b_mm_resolve;
            end
        end
        if (ret_hit) valid_d[mem2proc_data_tag] = 1'b0;
        if (alloc) begin
            valid_d[mem2proc_transaction_tag]       = 1'b1;
            owner_fetch_d[mem2proc_transaction_tag] = (winner == SEL_IF);
            squashed_d[mem2proc_transaction_tag]    = 1'b0;
            bm_d[mem2proc_transaction_tag]          = (winner == SEL_IF) ? '0
                                                      : (ld_bm & ~b_mm_resolve);
        end

        outstanding_d = outstanding_q;
        if (alloc && !ret_hit && (outstanding_q != {TAG_W{1'b1}}))
            outstanding_d = outstanding_q + 1'b1;
        else if (!alloc && ret_hit && (outstanding_q != '0))
            outstanding_d = outstanding_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q         <= 2'd0;
            valid_q       <= '0;
            owner_fetch_q <= '0;
            squashed_q    <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < N; i++) bm_q[i] <= '0;
        end else begin
            ptr_q         <= ptr_d;
            valid_q       <= valid_d;
            owner_fetch_q <= owner_fetch_d;
            squashed_q    <= squashed_d;
            outstanding_q <= outstanding_d;
            for (int i = 0; i < N; i++) bm_q[i] <= bm_d[i];
        end
    end

    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter: arbitration order, urgent stores,
// branch squash/resolve on outstanding loads, tag reuse and reset discard.
module tb_dmem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ld_req, if_req, st_req, st_urgent;
    logic [31:0] ld_addr, if_addr, st_addr;
    logic [3:0]  ld_bm;
    logic [63:0] st_data;
    logic        ld_ack, if_ack, st_ack;
    logic [3:0]  b_mm_resolve;
    logic        b_mm_mispred;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_transaction_tag, mem2proc_data_tag;
    logic [63:0] mem2proc_data;
    logic        ld_resp_valid, if_resp_valid;
    logic [63:0] ld_resp_data, if_resp_data;
    logic [3:0]  ld_resp_bm;
    logic [3:0]  outstanding;

    int errors = 0;
    int checks = 0;

    dmem_port_arbiter #(.B_W(4), .TAG_W(4)) dut (
        .clock(clock), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_bm(ld_bm),
        .if_req(if_req), .if_addr(if_addr),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_urgent(st_urgent),
        .ld_ack(ld_ack), .if_ack(if_ack), .st_ack(st_ack),
        .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data_tag(mem2proc_data_tag), .mem2proc_data(mem2proc_data),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_bm(ld_resp_bm),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .outstanding(outstanding)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        ld_req = 0; if_req = 0; st_req = 0; st_urgent = 0;
        ld_addr = 32'h1000; if_addr = 32'h2000; st_addr = 32'h3000;
        ld_bm = 4'b0000; st_data = 64'h5757_0000_0000_5757;
        b_mm_resolve = 4'b0000; b_mm_mispred = 0;
        mem2proc_transaction_tag = 0; mem2proc_data_tag = 0; mem2proc_data = 64'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick();

        // Reset cycle with every requester active: nothing granted or issued.
        ld_req = 1; if_req = 1; st_req = 1; mem2proc_transaction_tag = 4'd3;
        settle();
        check("rst_ld_ack", ld_ack, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_st_ack", st_ack, 0);
        check("rst_cmd", proc2mem_command, 0);
        tick();
        check("rst_outstanding", outstanding, 0);
        reset = 0;

        // Round robin with all requests held, tag 3.
        settle();
        check("rr0_ld_ack", ld_ack, 1);
        check("rr0_cmd", proc2mem_command, 1);
        check("rr0_addr", proc2mem_addr, 32'h1000);
        tick();
        settle();
        check("rr1_if_ack", if_ack, 1);
        check("rr1_ld_ack", ld_ack, 0);
        check("rr1_addr", proc2mem_addr, 32'h2000);
        tick();
        settle();
        check("rr2_st_ack", st_ack, 1);
        check("rr2_cmd", proc2mem_command, 2);
        check("rr2_data", proc2mem_data, 64'h5757_0000_0000_5757);
        tick();
        settle();
        check("rr3_ld_ack", ld_ack, 1);
        tick();
        check("rr_outstanding", outstanding, 3);

        // Reset discards entry 3; a later return for it is ignored.
        do_reset();
        mem2proc_data_tag = 4'd3; mem2proc_data = 64'h33;
        settle();
        check("discard_ld_resp", ld_resp_valid, 0);
        check("discard_if_resp", if_resp_valid, 0);
        tick();
        check("discard_outstanding", outstanding, 0);

        // Urgent store beats everything; pointer goes to 0 so load wins next.
        clear_inputs();
        ld_req = 1; if_req = 1; st_req = 1; st_urgent = 1; mem2proc_transaction_tag = 4'd3;
        settle();
        check("urg_st_ack", st_ack, 1);
        check("urg_ld_ack", ld_ack, 0);
        check("urg_cmd", proc2mem_command, 2);
        tick();
        st_urgent = 0;
        settle();
        check("urg_next_ld_ack", ld_ack, 1);
        tick();
        settle();
        check("urg_then_if_ack", if_ack, 1);
        tick();
        check("urg_outstanding", outstanding, 2);

        // Tag 0 refusal leaves pointer alone; retry with tag 2 is accepted.
        do_reset();
        ld_req = 1; ld_addr = 32'h100; mem2proc_transaction_tag = 4'd0;
        settle();
        check("tag0_ld_ack", ld_ack, 0);
        check("tag0_cmd", proc2mem_command, 1);
        tick();
        check("tag0_outstanding", outstanding, 0);
        mem2proc_transaction_tag = 4'd2;
        settle();
        check("tag2_ld_ack", ld_ack, 1);
        tick();
        ld_req = 0; mem2proc_transaction_tag = 0;
        check("tag2_outstanding", outstanding, 1);
        mem2proc_data_tag = 4'd2; mem2proc_data = 64'h1234;
        settle();
        check("tag2_resp_valid", ld_resp_valid, 1);
        check("tag2_resp_data", ld_resp_data, 64'h1234);
        check("tag2_resp_bm", ld_resp_bm, 4'b0000);
        tick();
        mem2proc_data_tag = 0;
        check("tag2_outstanding_after", outstanding, 0);

        // Mispredict squashes load tag 5; its return produces no response.
        ld_req = 1; ld_bm = 4'b0010; mem2proc_transaction_tag = 4'd5;
        settle();
        check("sq_ld_ack", ld_ack, 1);
        tick();
        clear_inputs();
        b_mm_resolve = 4'b0010; b_mm_mispred = 1;
        tick();
        b_mm_resolve = 0; b_mm_mispred = 0;
        mem2proc_data_tag = 4'd5; mem2proc_data = 64'h55;
        settle();
        check("sq_resp_valid", ld_resp_valid, 0);
        check("sq_outstanding_before", outstanding, 1);
        tick();
        mem2proc_data_tag = 0;
        check("sq_outstanding_after", outstanding, 0);

        // Correct resolve clears one mask bit of load tag 7.
        ld_req = 1; ld_bm = 4'b0011; mem2proc_transaction_tag = 4'd7;
        settle();
        check("res_ld_ack", ld_ack, 1);
        tick();
        clear_inputs();
        b_mm_resolve = 4'b0001;
        tick();
        b_mm_resolve = 0;
        mem2proc_data_tag = 4'd7; mem2proc_data = 64'hDEAD;
        settle();
        check("res_resp_valid", ld_resp_valid, 1);
        check("res_resp_bm", ld_resp_bm, 4'b0010);
        check("res_resp_data", ld_resp_data, 64'hDEAD);
        tick();
        mem2proc_data_tag = 0;
        check("res_outstanding", outstanding, 0);

        // A load killed by the current mispredict is not issued; fetch takes the slot.
        ld_req = 1; ld_bm = 4'b0100; b_mm_resolve = 4'b0100; b_mm_mispred = 1;
        mem2proc_transaction_tag = 4'd3;
        settle();
        check("kill_ld_ack", ld_ack, 0);
        check("kill_cmd", proc2mem_command, 0);
        if_req = 1; if_addr = 32'h200;
        settle();
        check("kill_if_ack", if_ack, 1);
        check("kill_if_addr", proc2mem_addr, 32'h200);
        clear_inputs();
        settle();

        // Tag 4 returns for a fetch while a new load takes tag 4 in the same cycle.
        if_req = 1; if_addr = 32'h300; mem2proc_transaction_tag = 4'd4;
        settle();
        check("reuse_if_ack", if_ack, 1);
        tick();
        clear_inputs();
        ld_req = 1; ld_bm = 4'b0001; mem2proc_transaction_tag = 4'd4;
        mem2proc_data_tag = 4'd4; mem2proc_data = 64'hAAAA;
        settle();
        check("reuse_if_resp", if_resp_valid, 1);
        check("reuse_if_data", if_resp_data, 64'hAAAA);
        check("reuse_ld_resp", ld_resp_valid, 0);
        check("reuse_ld_ack", ld_ack, 1);
        tick();
        clear_inputs();
        check("reuse_outstanding", outstanding, 1);
        mem2proc_data_tag = 4'd4; mem2proc_data = 64'hBBBB;
        settle();
        check("reuse_new_ld_resp", ld_resp_valid, 1);
        check("reuse_new_if_resp", if_resp_valid, 0);
        check("reuse_new_bm", ld_resp_bm, 4'b0001);
        tick();
        mem2proc_data_tag = 0;
        check("reuse_outstanding_after", outstanding, 0);

        // Return for a tag with no live entry.
        mem2proc_data_tag = 4'd9;
        settle();
        check("invalid_ld_resp", ld_resp_valid, 0);
        check("invalid_if_resp", if_resp_valid, 0);
        tick();
        check("invalid_outstanding", outstanding, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
